// File: rtl/pbit_sweep_scheduler.sv
// Gibbs-sampling sweep scheduler for a p-bit array.
// Updates each p-bit in turn with a one-hot enable, leaves settle gaps between
// updates, then hands a network snapshot to the consumer over valid/ready.
module pbit_sweep_scheduler #(
  parameter int unsigned NUM_PBITS     = 3,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SWEEP_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 stop,
  input  logic [SWEEP_W-1:0]   num_sweeps,
  input  logic [NUM_PBITS-1:0] pbit_state,
  output logic [NUM_PBITS-1:0] en,
  output logic                 busy,
  output logic [NUM_PBITS-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [SWEEP_W-1:0]   sweep_count,
  output logic                 sweep_done,
  output logic                 stalled
);

  localparam int unsigned IDX_W = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_SETTLE,
    S_CAPTURE,
    S_WAIT_OUT
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [SET_W-1:0]     settle_cnt_q;
  logic [SWEEP_W-1:0]   target_q;
  logic                 stop_pending_q;
  logic [NUM_PBITS-1:0] en_q;
  logic                 busy_q;
  logic [NUM_PBITS-1:0] sample_q;
  logic                 sample_valid_q;
  logic [SWEEP_W-1:0]   sweep_count_q;
  logic                 sweep_done_q;
  logic                 stalled_q;

  logic                 latch;
  logic                 xfer;
  logic                 last_slot;
  logic                 settle_last;
  logic                 finish_run;
  logic [SWEEP_W-1:0]   count_inc;
  logic [NUM_PBITS-1:0] next_slot_en;

  // Snapshot/handshake decisions and next-slot helpers for the current cycle.
  always_comb begin
    xfer         = sample_valid_q & sample_ready;
    latch        = ((state_q == S_CAPTURE) && (!sample_valid_q || sample_ready)) ||
                   ((state_q == S_WAIT_OUT) && sample_ready);
    count_inc    = (sweep_count_q == {SWEEP_W{1'b1}}) ? sweep_count_q
                                                      : sweep_count_q + SWEEP_W'(1);
    // A stop arriving in the latch cycle itself is honoured at that latch.
    finish_run   = stop_pending_q | stop |
                   ((target_q != '0) && (count_inc == target_q));
    last_slot    = (idx_q == IDX_W'(NUM_PBITS - 1));
    settle_last  = (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));
    next_slot_en = NUM_PBITS'(1) << (idx_q + IDX_W'(1));
  end

  // Sweep sequencer with registered enables, snapshot register and status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      settle_cnt_q   <= '0;
      target_q       <= '0;
      stop_pending_q <= 1'b0;
      en_q           <= '0;
      busy_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sweep_count_q  <= '0;
      sweep_done_q   <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;

      if (latch) begin
        sample_q       <= pbit_state;
        sample_valid_q <= 1'b1;
        sweep_done_q   <= 1'b1;
        sweep_count_q  <= count_inc;
      end else if (xfer) begin
        sample_valid_q <= 1'b0;
      end

      if ((state_q != S_IDLE) && stop) begin
        stop_pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          en_q <= '0;
          if (start) begin
            state_q        <= S_UPDATE;
            idx_q          <= '0;
            en_q           <= NUM_PBITS'(1);
            busy_q         <= 1'b1;
            sweep_count_q  <= '0;
            target_q       <= num_sweeps;
            stop_pending_q <= 1'b0;
          end
        end

        S_UPDATE: begin
          en_q <= '0;
          if (SETTLE_CYCLES > 0) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
          end else if (!last_slot) begin
            state_q <= S_UPDATE;
            idx_q   <= idx_q + IDX_W'(1);
            en_q    <= next_slot_en;
          end else begin
            state_q <= S_CAPTURE;
          end
        end

        S_SETTLE: begin
          en_q <= '0;
          if (!settle_last) begin
            settle_cnt_q <= settle_cnt_q + SET_W'(1);
          end else if (!last_slot) begin
            state_q <= S_UPDATE;
            idx_q   <= idx_q + IDX_W'(1);
            en_q    <= next_slot_en;
          end else begin
            state_q <= S_CAPTURE;
          end
        end

        S_CAPTURE, S_WAIT_OUT: begin
          en_q <= '0;
          if (latch) begin
            stalled_q <= 1'b0;
            if (finish_run) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_UPDATE;
              idx_q   <= '0;
              en_q    <= NUM_PBITS'(1);
            end
          end else begin
            state_q   <= S_WAIT_OUT;
            stalled_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          en_q      <= '0;
          busy_q    <= 1'b0;
          stalled_q <= 1'b0;
        end
      endcase
    end
  end

  assign en           = en_q;
  assign busy         = busy_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign sweep_count  = sweep_count_q;
  assign sweep_done   = sweep_done_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Bench for pbit_sweep_scheduler: two configurations (3 p-bits / 2 settle,
// 4 p-bits / no settle / 4-bit counter) checked every cycle against a
// sweep-phase reference model, plus directed scenario checks.
module tb_pbit_sweep_scheduler;

  localparam int unsigned NA = 3, SA = 2, WA = 16;
  localparam int unsigned NB = 4, SB = 0, WB = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, start, stop, sample_ready;
  logic [WA-1:0] num_a;
  logic [WB-1:0] num_b;
  logic [NA-1:0] pbit_a, en_a, sample_a;
  logic [NB-1:0] pbit_b, en_b, sample_b;
  logic [WA-1:0] sweep_count_a;
  logic [WB-1:0] sweep_count_b;
  logic          busy_a, valid_a, done_a, stalled_a;
  logic          busy_b, valid_b, done_b, stalled_b;

  pbit_sweep_scheduler #(.NUM_PBITS(NA), .SETTLE_CYCLES(SA), .SWEEP_W(WA)) u_dut_a (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .num_sweeps(num_a),
    .pbit_state(pbit_a), .en(en_a), .busy(busy_a), .sample(sample_a),
    .sample_valid(valid_a), .sample_ready(sample_ready),
    .sweep_count(sweep_count_a), .sweep_done(done_a), .stalled(stalled_a)
  );

  pbit_sweep_scheduler #(.NUM_PBITS(NB), .SETTLE_CYCLES(SB), .SWEEP_W(WB)) u_dut_b (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .num_sweeps(num_b),
    .pbit_state(pbit_b), .en(en_b), .busy(busy_b), .sample(sample_b),
    .sample_valid(valid_b), .sample_ready(sample_ready),
    .sweep_count(sweep_count_b), .sweep_done(done_b), .stalled(stalled_b)
  );

  // Reference: a run is a position (phase) inside a sweep of fixed period.
  typedef struct {
    bit run;
    bit wt;
    bit stp;
    int phase;
    int count;
    int target;
    int sample;
    bit valid;
    bit done;
  } mdl_t;

  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic mdl_t step(input mdl_t m, input int n, input int s, input int cmax,
                                input bit r, input bit st, input bit sp, input int num,
                                input int pb, input bit rdy);
    mdl_t x;
    bit   lat;
    bit   stop_now;
    int   period;
    x      = m;
    lat    = 1'b0;
    period = n * (1 + s) + 1;
    if (r) begin
      x = '{default: 0};
      return x;
    end
    x.done = 1'b0;
    if (!m.run) begin
      if (st) begin
        x.run = 1; x.wt = 0; x.phase = 0; x.count = 0; x.target = num; x.stp = 0;
      end
    end else begin
      stop_now = m.stp | sp;
      x.stp    = stop_now;
      if (m.phase == period - 1) begin
        if (!m.valid || rdy) lat = 1'b1;
        else x.wt = 1'b1;
      end else begin
        x.phase = m.phase + 1;
      end
      if (lat) begin
        x.sample = pb;
        x.count  = (m.count == cmax) ? cmax : m.count + 1;
        x.wt     = 1'b0;
        x.done   = 1'b1;
        if (stop_now || (m.target != 0 && x.count == m.target)) x.run = 1'b0;
        else x.phase = 0;
      end
    end
    if (lat) x.valid = 1'b1;
    else if (m.valid && rdy) x.valid = 1'b0;
    return x;
  endfunction

  function automatic int exp_en(input mdl_t m, input int n, input int s);
    if (!m.run || m.wt) return 0;
    if (m.phase < n * (1 + s) && (m.phase % (1 + s)) == 0) return 1 << (m.phase / (1 + s));
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance both models with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge CLK);
    ma = step(ma, NA, SA, (1 << WA) - 1, RST, start, stop, int'(num_a), int'(pbit_a), sample_ready);
    mb = step(mb, NB, SB, (1 << WB) - 1, RST, start, stop, int'(num_b), int'(pbit_b), sample_ready);
    #1;
    chk("a_en",      32'(en_a),          32'(exp_en(ma, NA, SA)));
    chk("a_busy",    32'(busy_a),        32'(ma.run));
    chk("a_sample",  32'(sample_a),      32'(ma.sample));
    chk("a_valid",   32'(valid_a),       32'(ma.valid));
    chk("a_count",   32'(sweep_count_a), 32'(ma.count));
    chk("a_done",    32'(done_a),        32'(ma.done));
    chk("a_stalled", 32'(stalled_a),     32'(ma.wt));
    chk("b_en",      32'(en_b),          32'(exp_en(mb, NB, SB)));
    chk("b_busy",    32'(busy_b),        32'(mb.run));
    chk("b_sample",  32'(sample_b),      32'(mb.sample));
    chk("b_valid",   32'(valid_b),       32'(mb.valid));
    chk("b_count",   32'(sweep_count_b), 32'(mb.count));
    chk("b_done",    32'(done_b),        32'(mb.done));
    chk("b_stalled", 32'(stalled_b),     32'(mb.wt));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget && (busy_a || busy_b); k++) cycle();
    chk(tag, 32'(busy_a | busy_b), 32'(0));
  endtask

  initial begin
    int d0, d1, nd;
    RST = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b1;
    num_a = '0; num_b = '0; pbit_a = '0; pbit_b = '0;
    ma = '{default: 0};
    mb = '{default: 0};
    cycle();
    cycle();
    RST = 1'b0;

    // Two-sweep run, snapshot follows pbit_state changes
    pbit_a = 3'b101; pbit_b = 4'b1001; num_a = WA'(2); num_b = WB'(2);
    start = 1'b1; cycle(); start = 1'b0;
    d0 = -1; d1 = -1;
    for (int k = 0; k < 60 && busy_a; k++) begin
      cycle();
      if (done_a) begin
        if (d0 < 0) begin
          d0 = k;
          chk("sample_first", 32'(sample_a), 32'(3'b101));
          pbit_a = 3'b010;
        end else begin
          d1 = k;
        end
      end
    end
    chk("done_gap",      32'(d1 - d0),       32'(10));
    chk("run1_busy",     32'(busy_a),        32'(0));
    chk("run1_count",    32'(sweep_count_a), 32'(2));
    chk("sample_second", 32'(sample_a),      32'(3'b010));
    wait_idle("run1_idle", 40);
    cycle();

    // Back-pressure: stall after the second sweep, one-cycle ready resumes
    num_a = '0; num_b = '0; sample_ready = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 40 && !stalled_a; k++) cycle();
    chk("stall_flag",  32'(stalled_a),     32'(1));
    chk("stall_en",    32'(en_a),          32'(0));
    chk("stall_count", 32'(sweep_count_a), 32'(1));
    sample_ready = 1'b1; cycle(); sample_ready = 1'b0;
    chk("resume_en",    32'(en_a),          32'(1));
    chk("resume_count", 32'(sweep_count_a), 32'(2));
    chk("resume_valid", 32'(valid_a),       32'(1));
    repeat (5) cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    sample_ready = 1'b1;
    wait_idle("stall_idle", 60);

    // Stop during slot 1 of sweep 3; a start mid-run is ignored
    start = 1'b1; cycle(); start = 1'b0;
    nd = 0;
    for (int k = 0; k < 40 && nd < 2; k++) begin
      cycle();
      if (done_a) nd++;
    end
    repeat (4) cycle();
    stop = 1'b1; start = 1'b1; cycle(); stop = 1'b0; start = 1'b0;
    for (int k = 0; k < 40 && busy_a; k++) cycle();
    chk("stop_count", 32'(sweep_count_a), 32'(3));
    chk("stop_busy",  32'(busy_a),        32'(0));
    wait_idle("stop_idle", 40);

    // Reset in a settle cycle aborts the run
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    RST = 1'b1; cycle(); RST = 1'b0;
    chk("rst_en",    32'(en_a),          32'(0));
    chk("rst_busy",  32'(busy_a),        32'(0));
    chk("rst_valid", 32'(valid_a),       32'(0));
    chk("rst_count", 32'(sweep_count_a), 32'(0));
    start = 1'b1; cycle(); start = 1'b0;
    chk("restart_en", 32'(en_a), 32'(1));
    RST = 1'b1; cycle(); RST = 1'b0;

    // Counter limits on the 4-bit configuration: all-ones target, then saturation
    num_a = WA'(3); num_b = WB'(15);
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 200 && busy_b; k++) cycle();
    chk("b_target_max", 32'(sweep_count_b), 32'(15));
    wait_idle("max_idle", 60);
    num_a = WA'(5); num_b = '0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (100) cycle();
    chk("b_saturate", 32'(sweep_count_b), 32'(15));
    chk("b_sat_busy", 32'(busy_b),        32'(1));
    stop = 1'b1; cycle(); stop = 1'b0;
    wait_idle("sat_idle", 40);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start        = ($urandom_range(0, 9) == 0);
      stop         = ($urandom_range(0, 29) == 0);
      sample_ready = ($urandom_range(0, 9) < 6);
      RST          = ($urandom_range(0, 299) == 0);
      pbit_a       = NA'($urandom);
      pbit_b       = NB'($urandom);
      num_a        = WA'($urandom_range(0, 4));
      num_b        = WB'($urandom_range(0, 15));
      cycle();
    end
    RST = 1'b0; start = 1'b0; stop = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
